gameplay_sequencer: RTL and testbench

//  Control FSM for one game of tower stacking. Drives the load, enable, score and chance

---
 rtl/gameplay_sequencer.sv | 169 ++++++++++++++++
 tb/tb_gameplay_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gameplay_sequencer.sv
// Control FSM for one game of tower stacking.
// Walks the gameplay datapath through clear / row advance / load / move / drop
// evaluation and reports game status for the display and HUD.
module gameplay_sequencer #(
    parameter int MAX_ROWS = 15,
    parameter int ROW_W    = 4,
    parameter int SETTLE   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             drop,
    input  logic             frame_tick,
    input  logic             o,
    input  logic             c,
    output logic             dp_clear,
    output logic             inc_row,
    output logic             ld_x,
    output logic             ld_y,
    output logic             ld_d,
    output logic             enable,
    output logic             sync,
    output logic             save_x,
    output logic             inc_score,
    output logic             dec_chances,
    output logic [ROW_W-1:0] rows_placed,
    output logic             playing,
    output logic             game_over,
    output logic             win
);

    localparam int WAIT_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_ADV,
        S_LOAD,
        S_MOVE,
        S_STOP,
        S_CHECK,
        S_HIT,
        S_MISS,
        S_WAIT,
        S_OVER,
        S_WIN
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_startQ;
    logic                r_dropQ;
    logic                w_startEdge;
    logic                w_dropEdge;
    logic [ROW_W-1:0]    r_rows;
    logic [ROW_W-1:0]    w_rowsInc;
    logic [WAIT_W-1:0]   r_waitCnt;

    assign w_startEdge = start & ~r_startQ;
    assign w_dropEdge  = drop & ~r_dropQ;
    assign w_rowsInc   = r_rows + ROW_W'(1);
    assign rows_placed = r_rows;

    // Remember last cycle's button levels so a press is seen as a single-cycle edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_startQ <= 1'b0;
            r_dropQ  <= 1'b0;
        end else begin
            r_startQ <= start;
            r_dropQ  <= drop;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Placed-row counter and post-miss settle counter; the WIN exit keeps the row count from wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rows    <= '0;
            r_waitCnt <= '0;
        end else begin
            if (r_state == S_CLEAR) begin
                r_rows <= '0;
            end else if (r_state == S_HIT) begin
                r_rows <= w_rowsInc;
            end
            if (r_state == S_MISS) begin
                r_waitCnt <= WAIT_W'(SETTLE - 1);
            end else if (r_state == S_WAIT && r_waitCnt != '0) begin
                r_waitCnt <= r_waitCnt - WAIT_W'(1);
            end
        end
    end

    // Next-state logic; a drop edge wins over a start edge while the block is moving.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_startEdge) w_nextState = S_CLEAR;
            S_CLEAR: w_nextState = S_ADV;
            S_ADV:   w_nextState = S_LOAD;
            S_LOAD:  w_nextState = S_MOVE;
            S_MOVE:  if (w_dropEdge) w_nextState = S_STOP;
            S_STOP:  w_nextState = S_CHECK;
            S_CHECK: w_nextState = (r_rows == '0 || o) ? S_HIT : S_MISS;
            S_HIT:   w_nextState = (w_rowsInc == ROW_W'(MAX_ROWS)) ? S_WIN : S_ADV;
            S_MISS:  w_nextState = S_WAIT;
            S_WAIT: begin
                if (r_waitCnt == '0) begin
                    w_nextState = c ? S_LOAD : S_OVER;
                end
            end
            S_OVER:  if (w_startEdge) w_nextState = S_CLEAR;
            S_WIN:   if (w_startEdge) w_nextState = S_CLEAR;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Moore strobes and status flags decoded from the current state.
    always_comb begin
        dp_clear    = 1'b0;
        inc_row     = 1'b0;
        ld_x        = 1'b0;
        ld_y        = 1'b0;
        ld_d        = 1'b0;
        enable      = 1'b0;
        save_x      = 1'b0;
        inc_score   = 1'b0;
        dec_chances = 1'b0;
        game_over   = 1'b0;
        win         = 1'b0;
        playing     = 1'b1;
        case (r_state)
            S_IDLE:  playing = 1'b0;
            S_CLEAR: dp_clear = 1'b1;
            S_ADV:   inc_row = 1'b1;
            S_LOAD: begin
                ld_x = 1'b1;
                ld_y = 1'b1;
                ld_d = 1'b1;
            end
            S_MOVE:  enable = 1'b1;
            S_HIT: begin
                save_x    = 1'b1;
                inc_score = 1'b1;
            end
            S_MISS:  dec_chances = 1'b1;
            S_OVER: begin
                playing   = 1'b0;
                game_over = 1'b1;
            end
            S_WIN: begin
                playing = 1'b0;
                win     = 1'b1;
            end
            default: ;
        endcase
        sync = frame_tick & enable;
    end

endmodule

// File: tb/tb_gameplay_sequencer.sv
// Self-checking bench for gameplay_sequencer with a game-level reference model.
module tb_gameplay_sequencer;

    localparam int MAXR   = 3;
    localparam int ROWW   = 4;
    localparam int SETTLE = 2;

    localparam int PH_IDLE = 0;
    localparam int PH_PLAY = 1;
    localparam int PH_OVER = 2;
    localparam int PH_WIN  = 3;

    logic            clk;
    logic            reset;
    logic            start;
    logic            drop;
    logic            frame_tick;
    logic            o;
    logic            c;
    logic            dp_clear;
    logic            inc_row;
    logic            ld_x;
    logic            ld_y;
    logic            ld_d;
    logic            enable;
    logic            sync;
    logic            save_x;
    logic            inc_score;
    logic            dec_chances;
    logic [ROWW-1:0] rows_placed;
    logic            playing;
    logic            game_over;
    logic            win;

    int errors = 0;
    int checks = 0;

    gameplay_sequencer #(
        .MAX_ROWS (MAXR),
        .ROW_W    (ROWW),
        .SETTLE   (SETTLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .drop        (drop),
        .frame_tick  (frame_tick),
        .o           (o),
        .c           (c),
        .dp_clear    (dp_clear),
        .inc_row     (inc_row),
        .ld_x        (ld_x),
        .ld_y        (ld_y),
        .ld_d        (ld_d),
        .enable      (enable),
        .sync        (sync),
        .save_x      (save_x),
        .inc_score   (inc_score),
        .dec_chances (dec_chances),
        .rows_placed (rows_placed),
        .playing     (playing),
        .game_over   (game_over),
        .win         (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame tick every third cycle, changed just after the rising edge.
    int tickCnt = 0;
    always @(posedge clk) begin
        #1;
        frame_tick = (tickCnt % 3 == 0);
        tickCnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- game-level reference model ----------------
    // Expected outputs are kept as a schedule of per-cycle words: a game event
    // (start or drop) appends the whole strobe sequence it must cause, and when
    // the schedule is empty the game phase decides the steady output.
    typedef struct {
        bit dpc;
        bit incRow;
        bit ld;
        bit en;
        bit saveX;
        bit incScore;
        bit decCh;
        bit play;
        bit over;
        bit winF;
        int rows;
        bit steady;
    } word_t;

    word_t expQ[$];
    word_t cur;
    int    phase = PH_IDLE;
    int    mRows = 0;
    bit    pS = 0;
    bit    pD = 0;
    bit    modelValid = 0;

    function automatic word_t busyWord(input int r);
        word_t w = '{default: 0};
        w.play = 1;
        w.rows = r;
        return w;
    endfunction

    function automatic word_t steadyWord();
        word_t w = '{default: 0};
        w.steady = 1;
        w.rows   = mRows;
        case (phase)
            PH_PLAY: begin w.play = 1; w.en = 1; end
            PH_OVER: w.over = 1;
            PH_WIN:  w.winF = 1;
            default: ;
        endcase
        return w;
    endfunction

    function automatic void pushNewRow();
        word_t w;
        w = busyWord(mRows); w.incRow = 1; expQ.push_back(w);
        w = busyWord(mRows); w.ld = 1;     expQ.push_back(w);
    endfunction

    function automatic void pushStart();
        word_t w;
        w = busyWord(mRows); w.dpc = 1; expQ.push_back(w);
        mRows = 0;
        pushNewRow();
        phase = PH_PLAY;
    endfunction

    function automatic void pushDrop(input bit oVal, input bit cVal);
        word_t w;
        bit    hit;
        hit = (mRows == 0) || oVal;
        expQ.push_back(busyWord(mRows));
        expQ.push_back(busyWord(mRows));
        if (hit) begin
            w = busyWord(mRows); w.saveX = 1; w.incScore = 1; expQ.push_back(w);
            mRows++;
            if (mRows == MAXR) phase = PH_WIN;
            else pushNewRow();
        end else begin
            w = busyWord(mRows); w.decCh = 1; expQ.push_back(w);
            for (int k = 0; k < SETTLE; k++) expQ.push_back(busyWord(mRows));
            if (cVal) begin
                w = busyWord(mRows); w.ld = 1; expQ.push_back(w);
            end else begin
                phase = PH_OVER;
            end
        end
    endfunction

    // Advance the model by one clock using the inputs seen at this edge.
    always @(posedge clk) begin
        bit sE;
        bit dE;
        if (reset) begin
            expQ.delete();
            phase      = PH_IDLE;
            mRows      = 0;
            pS         = 0;
            pD         = 0;
            cur        = steadyWord();
            modelValid = 1;
        end else if (modelValid) begin
            sE = start & ~pS;
            dE = drop & ~pD;
            pS = start;
            pD = drop;
            if (cur.steady) begin
                if (phase != PH_PLAY && sE) pushStart();
                else if (phase == PH_PLAY && dE) pushDrop(o, c);
            end
            if (expQ.size() > 0) cur = expQ.pop_front();
            else cur = steadyWord();
        end
    end

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("dp_clear",    dp_clear,    cur.dpc);
            checkOutput("inc_row",     inc_row,     cur.incRow);
            checkOutput("ld_x",        ld_x,        cur.ld);
            checkOutput("ld_y",        ld_y,        cur.ld);
            checkOutput("ld_d",        ld_d,        cur.ld);
            checkOutput("enable",      enable,      cur.en);
            checkOutput("sync",        sync,        cur.en & frame_tick);
            checkOutput("save_x",      save_x,      cur.saveX);
            checkOutput("inc_score",   inc_score,   cur.incScore);
            checkOutput("dec_chances", dec_chances, cur.decCh);
            checkOutput("playing",     playing,     cur.play);
            checkOutput("game_over",   game_over,   cur.over);
            checkOutput("win",         win,         cur.winF);
            checkOutput("rows_placed", rows_placed, cur.rows[ROWW-1:0]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic s, input logic d);
        start = s;
        drop  = d;
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit gotTick;
        start = 0; drop = 0; o = 0; c = 1; reset = 1; frame_tick = 0;
        repeat (3) step();
        checkOutput("lit_reset_rows",    rows_placed, 0);
        checkOutput("lit_reset_playing", playing,     0);
        reset = 0;

        // start sequence: clear, advance, load, move
        applyStimulus(1, 0);
        checkOutput("lit_clear",  dp_clear, 1);
        applyStimulus(0, 0);
        checkOutput("lit_adv",    inc_row,  1);
        applyStimulus(0, 0);
        checkOutput("lit_load",   ld_x,     1);
        applyStimulus(0, 0);
        checkOutput("lit_move",   enable,   1);
        gotTick = 0;
        for (int i = 0; i < 8 && !gotTick; i++) begin
            if (frame_tick) begin
                checkOutput("lit_sync", sync, 1);
                gotTick = 1;
            end else begin
                step();
            end
        end
        if (!gotTick) checkOutput("sync_tick_timeout", 0, 1);

        // first drop always scores, even without overlap
        o = 0; c = 1;
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        applyStimulus(0, 0);
        checkOutput("lit_hit1_save",  save_x,    1);
        checkOutput("lit_hit1_score", inc_score, 1);
        step();
        checkOutput("lit_rows1",      rows_placed, 1);
        checkOutput("lit_adv_after_hit", inc_row, 1);
        step();
        step();

        // miss with a chance left: retry the same row
        applyStimulus(0, 1);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("lit_miss_dec", dec_chances, 1);
        step();
        checkOutput("lit_wait1_dec", dec_chances, 0);
        step();
        step();
        checkOutput("lit_retry_ld",  ld_x,    1);
        checkOutput("lit_retry_row", inc_row, 0);
        step();

        // miss with no chance left: game over, then restart
        c = 0;
        applyStimulus(0, 1);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        step();
        step();
        step();
        checkOutput("lit_over", game_over, 1);
        applyStimulus(1, 0);
        checkOutput("lit_restart_clear", dp_clear, 1);
        applyStimulus(0, 0);
        checkOutput("lit_restart_rows", rows_placed, 0);
        step();
        step();

        // overlapping drops to a win; drop held through the check window
        o = 1; c = 1;
        repeat (7) applyStimulus(0, 1);
        applyStimulus(0, 0);
        checkOutput("lit_held_rows", rows_placed, 1);
        checkOutput("lit_held_move", enable, 1);
        applyStimulus(1, 1);
        checkOutput("lit_startdrop_stop", enable,   0);
        checkOutput("lit_startdrop_clr",  dp_clear, 0);
        repeat (5) applyStimulus(0, 0);
        checkOutput("lit_rows2", rows_placed, 2);
        applyStimulus(0, 1);
        repeat (3) applyStimulus(0, 0);
        checkOutput("lit_win",      win,         1);
        checkOutput("lit_win_rows", rows_placed, 3);
        repeat (3) begin
            applyStimulus(0, 1);
            applyStimulus(0, 0);
        end
        checkOutput("lit_win_hold_rows", rows_placed, 3);
        checkOutput("lit_win_hold",      win,         1);

        // new game, then reset in the middle of a drop
        applyStimulus(1, 0);
        checkOutput("lit_win_restart", dp_clear, 1);
        repeat (3) applyStimulus(0, 0);
        applyStimulus(0, 1);
        reset = 1;
        repeat (3) step();
        checkOutput("lit_midreset_state", playing | enable | dp_clear, 0);
        checkOutput("lit_midreset_rows",  rows_placed, 0);
        reset = 0;
        drop  = 0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
